// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP adder among NUM_REQ requesters.
// One operation in flight; operands and results pass through bit-exact.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no operation owned; req_ready offers the round-robin winner
// ISSUE   | operands latched, adder_in_stb high until adder_in_ack
// WAIT    | adder_z_ack high until the adder presents adder_z_stb
// RESPOND | resp_valid[grant_id] and resp_z held until the owner accepts
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     resp_valid,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic [31:0]            resp_z,
  output logic [31:0]            adder_a,
  output logic [31:0]            adder_b,
  output logic                   adder_in_stb,
  input  logic                   adder_in_ack,
  input  logic [31:0]            adder_z,
  input  logic                   adder_z_stb,
  output logic                   adder_z_ack,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic [15:0]            ops_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant_id;
  logic [31:0]      r_adder_a;
  logic [31:0]      r_adder_b;
  logic [31:0]      r_resp_z;
  logic [15:0]      r_ops_done;

  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [31:0]      w_win_a;
  logic [31:0]      w_win_b;
  logic             w_owner_ready;
  logic             w_accept;
  logic             w_result_take;
  logic             w_resp_done;

  // First pending requester scanning upward from r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req_valid[i] &&
            (((int'(r_rr_ptr) + k) % NUM_REQ) == i)) begin
          w_found  = 1'b1;
          w_winner = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    w_win_a       = '0;
    w_win_b       = '0;
    w_owner_ready = 1'b0;
    req_ready     = '0;
    resp_valid    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_win_a = req_a[32*i +: 32];
        w_win_b = req_b[32*i +: 32];
      end
      if (r_grant_id == IDW'(i)) begin
        w_owner_ready = resp_ready[i];
      end
      req_ready[i]  = (r_state == S_IDLE) && w_found && (w_winner == IDW'(i));
      resp_valid[i] = (r_state == S_RESPOND) && (r_grant_id == IDW'(i));
    end
  end

  assign w_accept      = (r_state == S_IDLE) && w_found;
  assign w_result_take = (r_state == S_WAIT) && adder_z_stb;
  assign w_resp_done   = (r_state == S_RESPOND) && w_owner_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found)       w_next = S_ISSUE;
      S_ISSUE:   if (adder_in_ack)  w_next = S_WAIT;
      S_WAIT:    if (adder_z_stb)   w_next = S_RESPOND;
      S_RESPOND: if (w_owner_ready) w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_adder_a  <= '0;
      r_adder_b  <= '0;
      r_resp_z   <= '0;
      r_ops_done <= '0;
    end else begin
      if (w_accept) begin
        r_adder_a  <= w_win_a;
        r_adder_b  <= w_win_b;
        r_grant_id <= w_winner;
      end
      if (w_result_take) begin
        r_resp_z <= adder_z;
      end
      // Next search starts just after the requester that was served.
      if (w_resp_done) begin
        r_ops_done <= r_ops_done + 16'd1;
        r_rr_ptr   <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + IDW'(1);
      end
    end
  end

  assign adder_a      = r_adder_a;
  assign adder_b      = r_adder_b;
  assign adder_in_stb = (r_state == S_ISSUE);
  assign adder_z_ack  = (r_state == S_WAIT);
  assign resp_z       = r_resp_z;
  assign busy         = (r_state != S_IDLE);
  assign grant_id     = r_grant_id;
  assign ops_done     = r_ops_done;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: a behavioural adder with programmable
// stalls, vector table, hand-written corner sequences and a randomized reference model.
module tb_fp_add_arbiter;

  localparam int N = 4;
  localparam logic [31:0] ONE = 32'h3F800000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]    resp_z, adder_a, adder_b, adder_z;
  logic           adder_in_stb, adder_in_ack, adder_z_ack, busy;
  logic           m_z_stb, sp_stb, adder_z_stb_w;
  logic [1:0]     grant_id;
  logic [15:0]    ops_done;

  assign adder_z_stb_w = m_z_stb | sp_stb;

  fp_add_arbiter #(.NUM_REQ(N), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z),
    .adder_a(adder_a), .adder_b(adder_b),
    .adder_in_stb(adder_in_stb), .adder_in_ack(adder_in_ack),
    .adder_z(adder_z), .adder_z_stb(adder_z_stb_w), .adder_z_ack(adder_z_ack),
    .busy(busy), .grant_id(grant_id), .ops_done(ops_done)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_ops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Positive-normal FP add with truncation; exact for the small values used here.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    logic [7:0]  e;
    logic [24:0] mx, my, s;
    int d;
    if (y[30:23] > x[30:23]) begin t = x; x = y; y = t; end
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    d  = int'(x[30:23]) - int'(y[30:23]);
    my = (d > 24) ? 25'd0 : (my >> d);
    s  = mx + my;
    e  = x[30:23];
    if (s[24]) begin s = s >> 1; e = e + 8'd1; end
    return {1'b0, e, s[22:0]};
  endfunction

  // Behavioural shared adder with programmable operand-ack and result delays.
  int in_delay, z_delay, m_phase, m_cnt;
  logic [31:0] m_res;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      m_phase = 0; m_cnt = 0; adder_in_ack = 1'b0; m_z_stb = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_z_stb = 1'b0;
          if (adder_in_stb) begin
            if (m_cnt >= in_delay) begin
              adder_in_ack = 1'b1; m_res = fadd(adder_a, adder_b); m_phase = 1; m_cnt = 0;
            end else m_cnt++;
          end
        end
        1: begin adder_in_ack = 1'b0; m_phase = 2; m_cnt = 0; end
        3: if (!adder_z_ack) begin m_z_stb = 1'b0; m_phase = 0; m_cnt = 0; end
        default: ;
      endcase
      if (m_phase == 2) begin
        if (m_cnt >= z_delay) begin m_z_stb = 1'b1; adder_z = m_res; m_phase = 3; end
        else m_cnt++;
      end
    end
  end

  logic [31:0] fa[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] fz[4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  int exp_ids[5];

  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] z; } vec_t;
  vec_t vecs[5];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; resp_ready = '1; sp_stb = 1'b0;
    in_delay = 0; z_delay = 0; exp_ops = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_table_ops();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = fa[i];
      req_b[32*i +: 32] = ONE;
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    #1;
    while (busy && t < 200) begin @(negedge clk); #1; t++; end
    chk({nm, " drain"}, 32'(busy), 32'd0);
  endtask

  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] z, input string nm);
    int t;
    @(negedge clk);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid = 4'(32'(1) << id);
    #1; t = 0;
    while (req_ready == '0 && t < 100) begin @(negedge clk); #1; t++; end
    chk({nm, " req_ready"}, 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk({nm, " adder_a"}, adder_a, a);
    chk({nm, " adder_b"}, adder_b, b);
    chk({nm, " in_stb"}, 32'(adder_in_stb), 32'd1);
    t = 0;
    while (resp_valid == '0 && t < 200) begin @(negedge clk); #1; t++; end
    chk({nm, " resp_valid"}, 32'(resp_valid), 32'(1) << id);
    chk({nm, " resp_z"}, resp_z, z);
    chk({nm, " grant_id"}, 32'(grant_id), 32'(id));
    exp_ops++;
    @(negedge clk); #1;
    chk({nm, " ops_done"}, 32'(ops_done), 32'(exp_ops));
    chk({nm, " idle"}, 32'(busy), 32'd0);
  endtask

  // Drives init_v, optionally dropping each request once accepted, and checks
  // that the first n responses come back in the order held in exp_ids.
  task automatic serve(input logic [N-1:0] init_v, input bit keep, input int n, input string nm);
    logic [N-1:0] acc;
    int got = 0;
    int t = 0;
    req_valid = init_v;
    while (got < n && t < 300) begin
      #1;
      acc = req_ready & req_valid;
      chk({nm, " req_ready onehot0"}, 32'($countones(req_ready) <= 1), 32'd1);
      chk({nm, " resp_valid onehot0"}, 32'($countones(resp_valid) <= 1), 32'd1);
      if (resp_valid != '0) begin
        chk({nm, " order"}, 32'(resp_valid), 32'(1) << exp_ids[got]);
        chk({nm, " z"}, resp_z, fz[exp_ids[got]]);
        got++;
      end
      t++;
      @(negedge clk);
      if (!keep) req_valid = req_valid & ~acc;
    end
    chk({nm, " count"}, 32'(got), 32'(n));
    req_valid = '0;
    wait_idle(nm);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] z_hold;
    int n_issue, n_wait, t, w, owner;
    logic [N-1:0] rv, want;
    logic [31:0] ra[4], rb[4], exp_z;
    int ptr;
    bit acc_pend, hs_pend;

    rst = 1'b0; req_valid = '0; resp_ready = '1; sp_stb = 1'b0;
    req_a = '0; req_b = '0; adder_z = '0; adder_in_ack = 1'b0; m_z_stb = 1'b0;
    in_delay = 0; z_delay = 0; m_phase = 0; m_cnt = 0; m_res = '0;

    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1] = '{1, 32'h40000000, 32'h3F800000, 32'h40400000};
    vecs[2] = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40400000};
    vecs[3] = '{3, 32'h40800000, 32'h3F000000, 32'h40900000};
    vecs[4] = '{0, 32'h40400000, 32'h40000000, 32'h40A00000};

    // Reset state
    do_reset();
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    chk("rst ops_done", 32'(ops_done), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst in_stb", 32'(adder_in_stb), 32'd0);
    chk("rst z_ack", 32'(adder_z_ack), 32'd0);
    chk("rst adder_a", adder_a, 32'd0);
    chk("rst adder_b", adder_b, 32'd0);
    chk("rst resp_z", resp_z, 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);

    // Vector table, first entry is the single-op case from reset
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].z, $sformatf("vec%0d", i));
    end

    // Fairness with all four requesting continuously
    do_reset();
    set_table_ops();
    exp_ids = '{0, 1, 2, 3, 0};
    @(negedge clk);
    serve(4'b1111, 1'b1, 5, "fair");

    // Pointer rotation: after serving 2, requester 3 beats 0
    do_reset();
    do_op(2, fa[2], ONE, fz[2], "rot pre");
    set_table_ops();
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    chk("rot first ready", 32'(req_ready), 32'b1000);
    exp_ids = '{3, 0, 0, 0, 0};
    serve(4'b1001, 1'b0, 2, "rot");

    // Backpressure on requester 1, others' resp_ready ignored
    do_reset();
    set_table_ops();
    resp_ready = 4'b1101;
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    chk("bp accept", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b0001;
    #1; t = 0;
    while (resp_valid == '0 && t < 100) begin @(negedge clk); #1; t++; end
    z_hold = resp_z;
    chk("bp z", z_hold, fz[1]);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk("bp resp_valid", 32'(resp_valid), 32'b0010);
      chk("bp resp_z", resp_z, z_hold);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      chk("bp busy", 32'(busy), 32'd1);
    end
    resp_ready = 4'b1111;
    @(negedge clk); #1;
    chk("bp release busy", 32'(busy), 32'd0);
    chk("bp release resp_valid", 32'(resp_valid), 32'd0);
    chk("bp release next", 32'(req_ready), 32'b0001);
    chk("bp ops_done", 32'(ops_done), 32'd1);
    @(negedge clk);
    req_valid = '0;
    wait_idle("bp");

    // Adder stalls
    do_reset();
    in_delay = 5; z_delay = 7;
    req_a[31:0] = fa[2]; req_b[31:0] = ONE;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    n_issue = 0; n_wait = 0; t = 0;
    #1;
    while (resp_valid == '0 && t < 60) begin
      if (adder_in_stb) begin
        n_issue++;
        chk("stall adder_a", adder_a, fa[2]);
        chk("stall adder_b", adder_b, ONE);
      end
      if (adder_z_ack) n_wait++;
      chk("stall strobes exclusive", 32'(adder_in_stb & adder_z_ack), 32'd0);
      @(negedge clk); #1; t++;
    end
    chk("stall issue cycles", 32'(n_issue), 32'd6);
    chk("stall wait cycles", 32'(n_wait), 32'd8);
    chk("stall resp_valid", 32'(resp_valid), 32'b0001);
    chk("stall resp_z", resp_z, fz[2]);
    wait_idle("stall");

    // Stray adder_z_stb while idle
    in_delay = 0; z_delay = 0;
    @(negedge clk);
    sp_stb = 1'b1;
    #1;
    chk("stray z_ack", 32'(adder_z_ack), 32'd0);
    @(negedge clk); #1;
    chk("stray busy", 32'(busy), 32'd0);
    chk("stray resp_valid", 32'(resp_valid), 32'd0);
    sp_stb = 1'b0;
    exp_ops = 1;
    do_op(1, fa[0], ONE, fz[0], "after stray");

    // Reset during WAIT
    z_delay = 30;
    req_a[127:96] = fa[3]; req_b[127:96] = ONE;
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    #1; t = 0;
    while (!adder_z_ack && t < 50) begin @(negedge clk); #1; t++; end
    chk("midrst in wait", 32'(adder_z_ack), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst in_stb", 32'(adder_in_stb), 32'd0);
    chk("midrst z_ack", 32'(adder_z_ack), 32'd0);
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst ops_done", 32'(ops_done), 32'd0);
    chk("midrst grant_id", 32'(grant_id), 32'd0);
    chk("midrst adder_a", adder_a, 32'd0);
    rst = 1'b1;
    exp_ops = 0; z_delay = 0;
    want = '0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); #1; want = want | resp_valid; end
    chk("midrst no stale resp", 32'(want), 32'd0);
    do_op(0, fa[1], ONE, fz[1], "midrst after");

    // Randomized traffic against a queue-free round-robin reference
    do_reset();
    rv = '0; ptr = 0; owner = 0; exp_z = '0; acc_pend = 0; hs_pend = 0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (acc_pend) begin rv[owner] = 1'b0; acc_pend = 0; end
      if (hs_pend) begin exp_ops++; ptr = (owner + 1) % N; hs_pend = 0; end
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          ra[i] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
          rb[i] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
          req_a[32*i +: 32] = ra[i];
          req_b[32*i +: 32] = rb[i];
          rv[i] = 1'b1;
        end
      end
      resp_ready = 4'($urandom);
      in_delay = $urandom_range(0, 3);
      z_delay = $urandom_range(0, 3);
      req_valid = rv;
      #1;
      chk("rand ops_done", 32'(ops_done), 32'(exp_ops & 16'hFFFF));
      if (!busy && rv != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && rv[(ptr + k) % N]) w = (ptr + k) % N;
        chk("rand grant", 32'(req_ready), 32'(1) << w);
        owner = w;
        exp_z = fadd(ra[w], rb[w]);
        acc_pend = 1;
      end else begin
        chk("rand no grant", 32'(req_ready), 32'd0);
      end
      if (resp_valid != '0) begin
        chk("rand resp_valid", 32'(resp_valid), 32'(1) << owner);
        chk("rand resp_z", resp_z, exp_z);
        if (resp_ready[owner]) hs_pend = 1;
      end
    end
    chk("rand progress", 32'(exp_ops > 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
